issue_ctrl: RTL and testbench
=============================

# issue_ctrl

Single-entry instruction holding stage and issue sequencer placed between fetch and the combinational decoder. It latches one fetched instruction, presents it to the decoder, and fires it into the execution unit the decoder selects when that unit has room. After a jump or branch (decoder `stall`), it blocks further fetch until the branch or jump unit resolves, then redirects the PC or resumes. It also keeps saturating stall and illegal-instruction counters for debug.

## Interface
Parameters:
- `NUM_UNITS`, 8: width of `unit_busy`; indexed by the decoder `ex_unit` code.
- `ERR_UNIT`, 0: `ex_unit` code meaning "no valid unit" (`EX_ERR_UNIT`).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `if_valid`  in  1  fetch presents an instruction.
- `if_inst`  in  32  fetched instruction word.
- `if_pc`  in  32  PC of `if_inst`.
- `if_ready`  out  1  stage accepts `if_inst` this cycle.
- `id_valid`  out  1  `id_inst` is held and presented to the decoder.
- `id_inst`  out  32  held instruction, drives decoder `inst`.
- `id_pc`  out  32  held PC, drives decoder `pc_addr`.
- `dec_ex_unit`  in  3  decoder `control.ex_unit` for `id_inst`.
- `dec_stall`  in  1  decoder `control.stall` for `id_inst`.
- `unit_busy`  in  NUM_UNITS  per-unit full flag; 1 blocks issue.
- `issue_fire`  out  1  held instruction issues this cycle.
- `issue_unit`  out  3  target unit; equals `dec_ex_unit` when `issue_fire`.
- `br_done`  in  1  branch/jump unit resolved the outstanding control instruction.
- `br_taken`  in  1  resolution is taken; valid with `br_done`.
- `br_target`  in  32  redirect target; valid with `br_done`.
- `pc_redirect_en`  out  1  one-cycle redirect pulse to fetch; fetch also discards its current word.
- `pc_redirect`  out  32  redirect PC.
- `stall_cnt`  out  16  saturating count of cycles in HOLD without fire, plus all cycles in WAIT_BR.
- `illegal_cnt`  out  8  saturating count of dropped instructions with `dec_ex_unit == ERR_UNIT`.

## Operation
- States: EMPTY, HOLD, WAIT_BR, REDIR.
- Reset (async): state EMPTY; `id_valid`, `issue_fire`, `pc_redirect_en`, `if_ready` 0; `id_inst`, `id_pc`, `pc_redirect`, `stall_cnt`, `illegal_cnt` 0. Once reset is released, `if_ready` follows the rules below.
- `id_valid` = (state == HOLD).
- `can_issue` = HOLD and `dec_ex_unit != ERR_UNIT` and `!unit_busy[dec_ex_unit]`. `issue_fire` = `can_issue` (combinational). `issue_unit` = `dec_ex_unit`.
- `drop` = HOLD and `dec_ex_unit == ERR_UNIT`. The instruction retires without issue and `illegal_cnt` increments, saturating at 255.
- `if_ready` = EMPTY, or (HOLD and (`drop` or (`issue_fire` and !`dec_stall`))). Always 0 in WAIT_BR and REDIR.
- Transitions:
  - EMPTY: on `if_valid`, load `if_inst`/`if_pc` and go to HOLD.
  - HOLD: on `issue_fire` with `dec_stall`, go to WAIT_BR. On `issue_fire` without `dec_stall`, or on `drop`: if `if_valid`, load the new word and stay in HOLD (back-to-back); otherwise go to EMPTY. If neither fires nor drops, hold and increment `stall_cnt`.
  - WAIT_BR: increment `stall_cnt` every cycle. On `br_done` with `br_taken`, register `pc_redirect` = `br_target` and go to REDIR. On `br_done` with !`br_taken`, go to EMPTY.
  - REDIR: `pc_redirect_en` = 1 for exactly this cycle. Next state is EMPTY.
- `br_done` outside WAIT_BR is ignored.
- `unit_busy` bits at indices ≥ NUM_UNITS are treated as busy.
- `stall_cnt` saturates at 0xFFFF. Counters change only as described.

## Timing
- Fetch-to-decoder latency: 1 cycle (word accepted at edge N is on `id_inst` after edge N).
- Issue is combinational within the HOLD cycle. Sustained throughput is 1 instruction/cycle with no stalls.
- Control instruction: the issue cycle is followed by ≥1 WAIT_BR cycle. The `br_done` edge is followed by REDIR (taken) or EMPTY (not taken). The earliest next accept is the cycle after REDIR, or the first EMPTY cycle.
- `pc_redirect`/`pc_redirect_en` are registered outputs.
- Async `rst` mid-WAIT_BR or mid-REDIR aborts immediately. No redirect pulse is emitted afterwards.

## Test plan
- Reset then stream ADDI words at pc 0x0,0x4,0x8 with `if_valid`=1, `dec_ex_unit`=ALU (1), `unit_busy`=0 -> `issue_fire` high on 3 consecutive cycles starting 1 cycle after the first accept; `stall_cnt`=0.
- Hold with `unit_busy[1]`=1 for 5 cycles, then release -> `issue_fire`=0 and `if_ready`=0 for 5 cycles, fire on the 6th; `stall_cnt`=5.
- Issue BEQ (`dec_stall`=1, unit 4); assert `br_done`=1, `br_taken`=1, `br_target`=0x100 three cycles later -> `pc_redirect_en` one pulse with `pc_redirect`=0x100 on the following cycle; `if_ready`=0 throughout WAIT_BR and REDIR.
- Same branch with `br_taken`=0 -> no pulse; state EMPTY the cycle after `br_done`; the next word is accepted.
- `dec_ex_unit`=0 for 300 consecutive words -> no `issue_fire`; `illegal_cnt` saturates at 255.
- Assert `rst` during WAIT_BR with `br_done` pending -> all outputs 0 immediately; no redirect pulse after release.

Source files
------------

// File: rtl/issue_ctrl.sv
// Single-entry instruction holding stage and issue sequencer between fetch and decode.
// Holds one word for the decoder, issues it to the selected unit, and sequences branch resolution.
module issue_ctrl #(
  parameter int         NUM_UNITS = 8,
  parameter logic [2:0] ERR_UNIT  = 3'd0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_valid,
  input  logic [31:0]          if_inst,
  input  logic [31:0]          if_pc,
  output logic                 if_ready,
  output logic                 id_valid,
  output logic [31:0]          id_inst,
  output logic [31:0]          id_pc,
  input  logic [2:0]           dec_ex_unit,
  input  logic                 dec_stall,
  input  logic [NUM_UNITS-1:0] unit_busy,
  output logic                 issue_fire,
  output logic [2:0]           issue_unit,
  input  logic                 br_done,
  input  logic                 br_taken,
  input  logic [31:0]          br_target,
  output logic                 pc_redirect_en,
  output logic [31:0]          pc_redirect,
  output logic [15:0]          stall_cnt,
  output logic [7:0]           illegal_cnt
);

  // state   | meaning
  // EMPTY   | no instruction held, fetch accepted
  // HOLD    | instruction presented to decoder, waiting for issue or drop
  // WAIT_BR | control instruction issued, fetch blocked until resolution
  // REDIR   | one-cycle redirect pulse to fetch
  typedef enum logic [1:0] {
    S_EMPTY,
    S_HOLD,
    S_WAIT_BR,
    S_REDIR
  } state_t;

  state_t state, state_nxt;

  logic [7:0] busy_pad;
  logic       can_issue;
  logic       drop;
  logic       load;
  logic       stall_inc;

  // Unit codes with no busy flag behind them are never issuable.
  for (genvar g = 0; g < 8; g++) begin : g_busy
    if (g < NUM_UNITS) begin : g_in
      assign busy_pad[g] = unit_busy[g];
    end else begin : g_out
      assign busy_pad[g] = 1'b1;
    end
  end

  always_comb begin
    can_issue = (state == S_HOLD) && (dec_ex_unit != ERR_UNIT) && !busy_pad[dec_ex_unit];
    drop      = (state == S_HOLD) && (dec_ex_unit == ERR_UNIT);
    if_ready  = !rst && ((state == S_EMPTY) || drop || (can_issue && !dec_stall));
    load      = if_ready && if_valid;
    stall_inc = ((state == S_HOLD) && !can_issue && !drop) || (state == S_WAIT_BR);
    state_nxt = state;
    case (state)
      S_EMPTY: begin
        if (if_valid) state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (can_issue && dec_stall) state_nxt = S_WAIT_BR;
        else if (can_issue || drop) state_nxt = if_valid ? S_HOLD : S_EMPTY;
      end
      S_WAIT_BR: begin
        if (br_done) state_nxt = br_taken ? S_REDIR : S_EMPTY;
      end
      S_REDIR: begin
        state_nxt = S_EMPTY;
      end
      default: begin
        state_nxt = S_EMPTY;
      end
    endcase
  end

  assign id_valid   = (state == S_HOLD);
  assign issue_fire = can_issue;
  assign issue_unit = dec_ex_unit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_EMPTY;
      id_inst        <= 32'd0;
      id_pc          <= 32'd0;
      pc_redirect    <= 32'd0;
      pc_redirect_en <= 1'b0;
      stall_cnt      <= 16'd0;
      illegal_cnt    <= 8'd0;
    end else begin
      state          <= state_nxt;
      pc_redirect_en <= (state_nxt == S_REDIR);
      if (load) begin
        id_inst <= if_inst;
        id_pc   <= if_pc;
      end
      if ((state == S_WAIT_BR) && br_done && br_taken) pc_redirect <= br_target;
      if (stall_inc && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
      if (drop && (illegal_cnt != 8'hFF)) illegal_cnt <= illegal_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_issue_ctrl.sv
// Self-checking bench for issue_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a queue-based behavioural model.
module tb_issue_ctrl;
  localparam int NUM_UNITS = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 if_valid;
  logic [31:0]          if_inst;
  logic [31:0]          if_pc;
  logic                 if_ready;
  logic                 id_valid;
  logic [31:0]          id_inst;
  logic [31:0]          id_pc;
  logic [2:0]           dec_ex_unit;
  logic                 dec_stall;
  logic [NUM_UNITS-1:0] unit_busy;
  logic                 issue_fire;
  logic [2:0]           issue_unit;
  logic                 br_done;
  logic                 br_taken;
  logic [31:0]          br_target;
  logic                 pc_redirect_en;
  logic [31:0]          pc_redirect;
  logic [15:0]          stall_cnt;
  logic [7:0]           illegal_cnt;

  issue_ctrl #(.NUM_UNITS(NUM_UNITS), .ERR_UNIT(3'd0)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .if_ready(if_ready),
    .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc),
    .dec_ex_unit(dec_ex_unit), .dec_stall(dec_stall), .unit_busy(unit_busy),
    .issue_fire(issue_fire), .issue_unit(issue_unit),
    .br_done(br_done), .br_taken(br_taken), .br_target(br_target),
    .pc_redirect_en(pc_redirect_en), .pc_redirect(pc_redirect),
    .stall_cnt(stall_cnt), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: at most one held word, plus branch-wait and redirect flags.
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } word_t;
  word_t       held[$];
  bit          m_wait;
  bit          m_redir;
  logic [31:0] m_redir_pc;
  int          m_stall;
  int          m_ill;

  logic        obs_fire, obs_ready, obs_redir_en;
  logic [31:0] obs_redir;

  task automatic model_clear();
    held.delete();
    m_wait = 0; m_redir = 0; m_redir_pc = 32'd0; m_stall = 0; m_ill = 0;
  endtask

  task automatic idle_inputs();
    if_valid = 0; if_inst = 0; if_pc = 0; dec_ex_unit = 3'd1; dec_stall = 0;
    unit_busy = '0; br_done = 0; br_taken = 0; br_target = 0;
  endtask

  task automatic apply_reset();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    model_clear();
  endtask

  // One clock: compare outputs at the falling edge, advance the model, return at posedge+1.
  task automatic cycle();
    logic busy_b, e_fire, e_drop, e_ready;
    @(negedge clk);
    busy_b  = (int'(dec_ex_unit) < NUM_UNITS) ? unit_busy[dec_ex_unit] : 1'b1;
    e_drop  = (held.size() == 1) && (dec_ex_unit == 3'd0);
    e_fire  = (held.size() == 1) && (dec_ex_unit != 3'd0) && !busy_b;
    e_ready = ((held.size() == 0) && !m_wait && !m_redir) || e_drop || (e_fire && !dec_stall);
    obs_fire = issue_fire; obs_ready = if_ready; obs_redir_en = pc_redirect_en; obs_redir = pc_redirect;

    checks++;
    if (if_ready !== e_ready) begin errors++; $display("FAIL if_ready got %0b exp %0b at %0t", if_ready, e_ready, $time); end
    checks++;
    if (id_valid !== (held.size() == 1)) begin errors++; $display("FAIL id_valid got %0b exp %0b at %0t", id_valid, held.size() == 1, $time); end
    checks++;
    if (issue_fire !== e_fire) begin errors++; $display("FAIL issue_fire got %0b exp %0b at %0t", issue_fire, e_fire, $time); end
    if (held.size() == 1) begin
      checks++;
      if (id_inst !== held[0].inst || id_pc !== held[0].pc) begin
        errors++; $display("FAIL id_word got %h/%h exp %h/%h at %0t", id_inst, id_pc, held[0].inst, held[0].pc, $time);
      end
    end
    if (e_fire) begin
      checks++;
      if (issue_unit !== dec_ex_unit) begin errors++; $display("FAIL issue_unit got %0d exp %0d at %0t", issue_unit, dec_ex_unit, $time); end
    end
    checks++;
    if (pc_redirect_en !== m_redir) begin errors++; $display("FAIL redirect_en got %0b exp %0b at %0t", pc_redirect_en, m_redir, $time); end
    checks++;
    if (pc_redirect !== m_redir_pc) begin errors++; $display("FAIL pc_redirect got %h exp %h at %0t", pc_redirect, m_redir_pc, $time); end
    checks++;
    if (stall_cnt !== 16'(m_stall)) begin errors++; $display("FAIL stall_cnt got %0d exp %0d at %0t", stall_cnt, m_stall, $time); end
    checks++;
    if (illegal_cnt !== 8'(m_ill)) begin errors++; $display("FAIL illegal_cnt got %0d exp %0d at %0t", illegal_cnt, m_ill, $time); end

    if (m_redir) begin
      m_redir = 0;
    end else if (m_wait) begin
      if (m_stall < 65535) m_stall++;
      if (br_done) begin
        m_wait = 0;
        if (br_taken) begin m_redir = 1; m_redir_pc = br_target; end
      end
    end else begin
      if (held.size() == 1) begin
        if (e_fire && dec_stall) begin held.delete(); m_wait = 1; end
        else if (e_fire || e_drop) begin
          if (e_drop && m_ill < 255) m_ill++;
          held.delete();
        end else if (m_stall < 65535) m_stall++;
      end
      if (e_ready && if_valid) held.push_back('{if_inst, if_pc});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({if_ready, id_valid, issue_fire, pc_redirect_en} !== 4'b0) begin
      errors++; $display("FAIL reset_flags got %b exp 0000", {if_ready, id_valid, issue_fire, pc_redirect_en});
    end
    checks++;
    if ({id_inst, id_pc, pc_redirect, stall_cnt, illegal_cnt} !== '0) begin
      errors++; $display("FAIL reset_regs got %h/%h/%h/%0d/%0d exp all 0", id_inst, id_pc, pc_redirect, stall_cnt, illegal_cnt);
    end
    rst = 0;
    model_clear();
  endtask

  task automatic test_stream();
    logic [4:0] pat;
    idle_inputs(); apply_reset();
    if_valid = 1; dec_ex_unit = 3'd1;
    for (int i = 0; i < 3; i++) begin
      if_inst = 32'h00000093 | (32'(i + 1) << 20); if_pc = 32'(i * 4);
      cycle(); pat[i] = obs_fire;
    end
    if_valid = 0;
    for (int i = 3; i < 5; i++) begin cycle(); pat[i] = obs_fire; end
    checks++;
    if (pat !== 5'b01110) begin errors++; $display("FAIL stream_fire_pattern got %b exp 01110", pat); end
    checks++;
    if (stall_cnt !== 16'd0) begin errors++; $display("FAIL stream_stall got %0d exp 0", stall_cnt); end
  endtask

  task automatic test_busy();
    int fires, readies;
    idle_inputs(); apply_reset();
    if_valid = 1; if_inst = 32'h00500093; if_pc = 32'h40; dec_ex_unit = 3'd1;
    cycle();
    unit_busy = 8'h02; if_inst = 32'h00600093; if_pc = 32'h44;
    fires = 0; readies = 0;
    repeat (5) begin cycle(); fires += int'(obs_fire); readies += int'(obs_ready); end
    checks++;
    if (fires != 0 || readies != 0) begin errors++; $display("FAIL busy_block fire=%0d ready=%0d exp 0/0", fires, readies); end
    unit_busy = 8'h00;
    cycle();
    checks++;
    if (obs_fire !== 1'b1) begin errors++; $display("FAIL busy_release fire got %0b exp 1", obs_fire); end
    checks++;
    if (stall_cnt !== 16'd5) begin errors++; $display("FAIL busy_stall got %0d exp 5", stall_cnt); end
  endtask

  task automatic test_branch(input bit taken);
    int pulses, readies;
    logic [31:0] seen;
    idle_inputs(); apply_reset();
    if_valid = 1; if_inst = 32'h00208463; if_pc = 32'h80; dec_ex_unit = 3'd4; dec_stall = 1;
    cycle();
    if_inst = 32'h00000013; if_pc = 32'h84;
    cycle();
    pulses = 0; readies = 0; seen = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin br_done = 1; br_taken = taken; br_target = 32'h100; end
      cycle(); readies += int'(obs_ready);
    end
    br_done = 0; br_taken = 0; dec_ex_unit = 3'd1; dec_stall = 0;
    if (taken) begin
      cycle(); readies += int'(obs_ready); pulses += int'(obs_redir_en);
      if (obs_redir_en) seen = obs_redir;
    end
    cycle(); pulses += int'(obs_redir_en);
    checks++;
    if (readies != 0) begin errors++; $display("FAIL br_ready_blocked got %0d ready cycles exp 0", readies); end
    checks++;
    if (obs_ready !== 1'b1) begin errors++; $display("FAIL br_resume_ready got %0b exp 1", obs_ready); end
    checks++;
    if (pulses != (taken ? 1 : 0)) begin errors++; $display("FAIL br_pulses taken=%0b got %0d exp %0d", taken, pulses, taken ? 1 : 0); end
    if (taken) begin
      checks++;
      if (seen !== 32'h100) begin errors++; $display("FAIL br_target got %h exp 00000100", seen); end
    end
    checks++;
    if (stall_cnt !== 16'd3) begin errors++; $display("FAIL br_stall got %0d exp 3", stall_cnt); end
  endtask

  task automatic test_illegal();
    int fires;
    idle_inputs(); apply_reset();
    if_valid = 1; dec_ex_unit = 3'd0; fires = 0;
    for (int i = 0; i < 301; i++) begin
      if_inst = 32'hFFFF_FFFF ^ 32'(i); if_pc = 32'(i * 4);
      cycle(); fires += int'(obs_fire);
    end
    checks++;
    if (fires != 0) begin errors++; $display("FAIL illegal_fires got %0d exp 0", fires); end
    checks++;
    if (illegal_cnt !== 8'd255) begin errors++; $display("FAIL illegal_sat got %0d exp 255", illegal_cnt); end
  endtask

  task automatic test_reset_mid_branch();
    int pulses;
    idle_inputs(); apply_reset();
    if_valid = 1; if_inst = 32'h00000063; if_pc = 32'hC0; dec_ex_unit = 3'd4; dec_stall = 1;
    cycle();
    if_valid = 0;
    cycle();
    cycle();
    br_done = 1; br_taken = 1; br_target = 32'h200;
    #2 rst = 1;
    #1;
    checks++;
    if ({if_ready, id_valid, issue_fire, pc_redirect_en} !== 4'b0) begin
      errors++; $display("FAIL midrst_flags got %b exp 0000", {if_ready, id_valid, issue_fire, pc_redirect_en});
    end
    checks++;
    if ({id_inst, id_pc, pc_redirect, stall_cnt, illegal_cnt} !== '0) begin
      errors++; $display("FAIL midrst_regs got %h/%h/%h/%0d/%0d exp all 0", id_inst, id_pc, pc_redirect, stall_cnt, illegal_cnt);
    end
    @(posedge clk); #1;
    rst = 0;
    model_clear();
    pulses = 0;
    repeat (4) begin cycle(); pulses += int'(obs_redir_en); end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL midrst_pulse got %0d exp 0", pulses); end
  endtask

  task automatic test_random();
    idle_inputs(); apply_reset();
    for (int i = 0; i < 3000; i++) begin
      if_valid    = ($urandom_range(0, 3) != 0);
      if_inst     = $urandom;
      if_pc       = $urandom & 32'hFFFF_FFFC;
      dec_ex_unit = ($urandom_range(0, 9) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      dec_stall   = ($urandom_range(0, 7) == 0);
      unit_busy   = ($urandom_range(0, 2) == 0) ? NUM_UNITS'($urandom) : '0;
      br_done     = ($urandom_range(0, 3) == 0);
      br_taken    = $urandom_range(0, 1);
      br_target   = $urandom;
      cycle();
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_busy();
    test_branch(1'b1);
    test_branch(1'b0);
    test_illegal();
    test_reset_mid_branch();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
